// File: rtl/mov_exec_fsm_pkg.sv
// Shared types and helpers for the register-move execution FSM.
// States, opcodes, register index names and immediate extension.
package mov_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRIVE = 3'd2,
    LATCH = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [3:0] OPC_MOVI_D = 4'b0111;
  localparam logic [3:0] OPC_MOV_D  = 4'b0110;

  localparam int G0 = 0;
  localparam int P0 = 1;
  localparam int G1 = 2;
  localparam int G2 = 3;
  localparam int G3 = 4;
  localparam int P1 = 5;

  // Field is zero-padded by the caller; bits at and above fw are refilled.
  function automatic logic [31:0] extend(
    input logic [31:0] f,
    input int          fw,
    input bit          sx
  );
    logic [31:0] r;
    r = f;
    for (int i = 0; i < 32; i++) begin
      if (i >= fw) r[i] = sx & f[5'(fw - 1)];
    end
    return r;
  endfunction

endpackage

// File: rtl/mov_exec_fsm_if.sv
// Controller-side bundle for the register-move FSM.
// Request/instruction in, bus drive and load enables out.
interface mov_exec_fsm_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 6,
  parameter int INSTR_W  = 16
);
  logic                start;
  logic [INSTR_W-1:0]  instr;
  logic                busy;
  logic                pc_inc;
  logic                imm_out;
  logic [DATA_W-1:0]   imm_val;
  logic [NUM_REGS-1:0] reg_out;
  logic [NUM_REGS-1:0] reg_in;
  logic                done;
  logic                err;

  modport master (
    output start, instr,
    input  busy, pc_inc, imm_out, imm_val,
    input  reg_out, reg_in, done, err
  );

  modport slave (
    input  start, instr,
    output busy, pc_inc, imm_out, imm_val,
    output reg_out, reg_in, done, err
  );
endinterface

// File: rtl/mov_exec_fsm_decode.sv
// Combinational legality check and one-hot dst/src select.
// Reusable by other per-opcode FSMs sharing the instruction format.
module mov_decode #(
  parameter int         NUM_REGS = 6,
  parameter int         FIELD_W  = 6,
  parameter int         OPC_W    = 4,
  parameter logic [3:0] OPC_MOVI = 4'b0111,
  parameter logic [3:0] OPC_MOV  = 4'b0110,
  localparam int INSTR_W = OPC_W + 2 * FIELD_W
) (
  input  logic [INSTR_W-1:0]  i_instr,
  output logic                o_legal,
  output logic                o_is_movi,
  output logic [NUM_REGS-1:0] o_dst_oh,
  output logic [NUM_REGS-1:0] o_src_oh
);
  localparam logic [31:0] NR = 32'(NUM_REGS);

  logic [OPC_W-1:0]   w_opc;
  logic [FIELD_W-1:0] w_dst;
  logic [FIELD_W-1:0] w_src;
  logic               w_dst_ok;
  logic               w_src_ok;
  logic               w_movi;
  logic               w_mov;

  assign w_opc = i_instr[INSTR_W-1 -: OPC_W];
  assign w_dst = i_instr[2*FIELD_W-1 -: FIELD_W];
  assign w_src = i_instr[FIELD_W-1:0];

  assign w_dst_ok = 32'(w_dst) < NR;
  assign w_src_ok = 32'(w_src) < NR;
  assign w_movi   = w_opc == OPC_W'(OPC_MOVI);
  assign w_mov    = w_opc == OPC_W'(OPC_MOV);

  assign o_dst_oh = w_dst_ok ? NUM_REGS'(1) << w_dst : '0;
  assign o_src_oh = w_src_ok ? NUM_REGS'(1) << w_src : '0;

  always_comb begin
    o_legal   = 1'b0;
    o_is_movi = 1'b0;
    unique case (1'b1)
      w_movi: begin
        o_is_movi = 1'b1;
        o_legal   = w_dst_ok;
      end
      w_mov:   o_legal = w_dst_ok & w_src_ok;
      default: ;
    endcase
  end
endmodule

// File: rtl/mov_exec_fsm.sv
// MOVI/MOV execution FSM with start/busy/done handshake.
// Outputs are registered for the state being entered.
module mov_exec_fsm
  import mov_pkg::*;
#(
  parameter int         DATA_W   = 16,
  parameter int         NUM_REGS = 6,
  parameter int         FIELD_W  = 6,
  parameter int         OPC_W    = 4,
  parameter logic [3:0] OPC_MOVI = OPC_MOVI_D,
  parameter logic [3:0] OPC_MOV  = OPC_MOV_D,
  parameter bit         SIGN_EXT = 1'b0,
  localparam int INSTR_W = OPC_W + 2 * FIELD_W
) (
  input logic           clk,
  input logic           rst_n,
  mov_exec_fsm_if.slave bus
);
  state_e              r_state;
  logic [INSTR_W-1:0]  r_instr;
  logic                r_busy;
  logic                r_pc_inc;
  logic                r_imm_out;
  logic [DATA_W-1:0]   r_imm_val;
  logic [NUM_REGS-1:0] r_reg_out;
  logic [NUM_REGS-1:0] r_reg_in;
  logic                r_done;
  logic                r_err;

  logic                w_legal;
  logic                w_is_movi;
  logic [NUM_REGS-1:0] w_dst_oh;
  logic [NUM_REGS-1:0] w_src_oh;
  logic [FIELD_W-1:0]  w_imm;

  assign w_imm = r_instr[FIELD_W-1:0];

  mov_decode #(
    .NUM_REGS (NUM_REGS),
    .FIELD_W  (FIELD_W),
    .OPC_W    (OPC_W),
    .OPC_MOVI (OPC_MOVI),
    .OPC_MOV  (OPC_MOV)
  ) u_dec (
    .i_instr   (r_instr),
    .o_legal   (w_legal),
    .o_is_movi (w_is_movi),
    .o_dst_oh  (w_dst_oh),
    .o_src_oh  (w_src_oh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_instr   <= '0;
      r_busy    <= 1'b0;
      r_pc_inc  <= 1'b0;
      r_imm_out <= 1'b0;
      r_imm_val <= '0;
      r_reg_out <= '0;
      r_reg_in  <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_pc_inc <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_instr  <= bus.instr;
            r_state  <= FETCH;
            r_busy   <= 1'b1;
            r_pc_inc <= 1'b1;
          end
        end
        FETCH: begin
          if (w_legal) begin
            r_state   <= DRIVE;
            r_imm_out <= w_is_movi;
            r_reg_out <= w_is_movi ? '0 : w_src_oh;
            if (w_is_movi)
              r_imm_val <= DATA_W'(extend(32'(w_imm), FIELD_W, SIGN_EXT));
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end
        end
        DRIVE: begin
          r_state  <= LATCH;
          r_reg_in <= w_dst_oh;
        end
        LATCH: begin
          r_state   <= DONE;
          r_imm_out <= 1'b0;
          r_imm_val <= '0;
          r_reg_out <= '0;
          r_reg_in  <= '0;
          r_done    <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.pc_inc  = r_pc_inc;
  assign bus.imm_out = r_imm_out;
  assign bus.imm_val = r_imm_val;
  assign bus.reg_out = r_reg_out;
  assign bus.reg_in  = r_reg_in;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
endmodule

// File: tb/tb_mov_exec_fsm.sv
// Bench for mov_exec_fsm: zero- and sign-extending instances side by side.
// Each cycle is checked against a per-cycle behavioural trace model.
module tb_mov_exec_fsm;
  import mov_pkg::*;

  typedef logic [32:0] vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mov_exec_fsm_if #(.DATA_W(16), .NUM_REGS(6), .INSTR_W(16)) bz ();
  mov_exec_fsm_if #(.DATA_W(16), .NUM_REGS(6), .INSTR_W(16)) bs ();

  mov_exec_fsm #(.SIGN_EXT(1'b0)) u_z (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bz)
  );

  mov_exec_fsm #(.SIGN_EXT(1'b1)) u_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {busy,pc_inc,imm_out,imm_val,reg_out,reg_in,done,err}
  // for cycle k after the accepting edge.
  function automatic vec_t model(
    input logic [15:0] ins,
    input bit          sx,
    input int          k
  );
    int          opc;
    int          dst;
    int          src;
    int          imm;
    bit          mvi;
    bit          mv;
    bit          legal;
    logic        b;
    logic        pc;
    logic        io;
    logic        dn;
    logic        er;
    logic [15:0] iv;
    logic [5:0]  ro;
    logic [5:0]  ri;
    opc = int'(ins[15:12]);
    dst = int'(ins[11:6]);
    src = int'(ins[5:0]);
    mvi = opc == 7;
    mv  = opc == 6;
    legal = (mvi || mv) && dst < 6 && (mvi || src < 6);
    imm = (sx && src >= 32) ? src - 64 + 65536 : src;
    b = 0; pc = 0; io = 0; dn = 0; er = 0;
    iv = 0; ro = 0; ri = 0;
    if (k == 1) begin
      b = 1; pc = 1;
    end else if (legal && (k == 2 || k == 3)) begin
      b = 1;
      if (mvi) begin
        io = 1; iv = imm[15:0];
      end else begin
        ro = 6'(1 << src);
      end
      if (k == 3) ri = 6'(1 << dst);
    end else if (legal && k == 4) begin
      b = 1; dn = 1;
    end else if (!legal && k == 2) begin
      b = 1; dn = 1; er = 1;
    end
    return {b, pc, io, iv, ro, ri, dn, er};
  endfunction

  task automatic drive(input logic s, input logic [15:0] ins);
    bz.start = s; bs.start = s;
    bz.instr = ins; bs.instr = ins;
  endtask

  task automatic issue(input logic [15:0] ins);
    @(negedge clk);
    drive(1'b1, ins);
  endtask

  task automatic grab(output vec_t oz, output vec_t os);
    oz = {bz.busy, bz.pc_inc, bz.imm_out, bz.imm_val,
          bz.reg_out, bz.reg_in, bz.done, bz.err};
    os = {bs.busy, bs.pc_inc, bs.imm_out, bs.imm_val,
          bs.reg_out, bs.reg_in, bs.done, bs.err};
  endtask

  task automatic test_reset();
    vec_t oz, os;
    rst_n = 1'b0;
    drive(1'b0, 16'h0);
    repeat (2) @(negedge clk);
    grab(oz, os);
    n_vec++;
    if (oz !== '0) begin
      n_err++;
      $display("FAIL reset_z got %h exp 0", oz);
    end
    n_vec++;
    if (os !== '0) begin
      n_err++;
      $display("FAIL reset_s got %h exp 0", os);
    end
    rst_n = 1'b1;
    @(negedge clk);
    grab(oz, os);
    n_vec++;
    if (oz !== '0 || os !== '0) begin
      n_err++;
      $display("FAIL idle_after_reset got %h/%h exp 0", oz, os);
    end
  endtask

  task automatic test_instr(input string nm, input logic [15:0] ins);
    vec_t oz, os;
    issue(ins);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, 16'(~ins));
      grab(oz, os);
      n_vec++;
      if (oz !== model(ins, 1'b0, k)) begin
        n_err++;
        $display("FAIL %s_z cyc%0d got %h exp %h",
                 nm, k, oz, model(ins, 1'b0, k));
      end
      n_vec++;
      if (os !== model(ins, 1'b1, k)) begin
        n_err++;
        $display("FAIL %s_s cyc%0d got %h exp %h",
                 nm, k, os, model(ins, 1'b1, k));
      end
    end
  endtask

  task automatic test_start_busy();
    vec_t oz, os;
    logic [15:0] ins;
    ins = 16'h7045;
    issue(ins);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, ins);
      if (k == 2) drive(1'b1, 16'h6084);
      if (k == 3) drive(1'b0, 16'h6084);
      if (k == 4) drive(1'b1, 16'h70C1);
      if (k == 5) drive(1'b0, 16'h0);
      grab(oz, os);
      n_vec++;
      if (oz !== model(ins, 1'b0, k)) begin
        n_err++;
        $display("FAIL busy_start_z cyc%0d got %h exp %h",
                 k, oz, model(ins, 1'b0, k));
      end
      n_vec++;
      if (os !== model(ins, 1'b1, k)) begin
        n_err++;
        $display("FAIL busy_start_s cyc%0d got %h exp %h",
                 k, os, model(ins, 1'b1, k));
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t oz, os;
    logic [15:0] ins;
    ins = 16'h7045;
    issue(ins);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, ins);
      grab(oz, os);
      n_vec++;
      if (oz !== model(ins, 1'b0, k)) begin
        n_err++;
        $display("FAIL rst_mid_pre cyc%0d got %h exp %h",
                 k, oz, model(ins, 1'b0, k));
      end
    end
    rst_n = 1'b0;
    #1;
    grab(oz, os);
    n_vec++;
    if (oz !== '0 || os !== '0) begin
      n_err++;
      $display("FAIL rst_mid_async got %h/%h exp 0", oz, os);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_instr("after_rst", 16'h6084);
  endtask

  task automatic test_random();
    logic [15:0] ins;
    logic [3:0]  opc;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    opc = 4'h7;
        2:       opc = 4'h6;
        default: opc = 4'($urandom_range(0, 15));
      endcase
      ins[15:12] = opc;
      ins[11:6]  = 6'($urandom_range(0, 7));
      ins[5:0]   = (opc == 4'h6) ? 6'($urandom_range(0, 7))
                                 : 6'($urandom_range(0, 63));
      test_instr("rand", ins);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_instr("movi", 16'h7045);
    test_instr("sext", 16'h70FF);
    test_instr("mov", 16'h6084);
    test_instr("mov_same", 16'h6145);
    test_instr("bad_dst", 16'h71C1);
    test_instr("bad_opc", 16'h3041);
    test_instr("bad_src", 16'h6047);
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mov_exec_fsm.md
Name: mov_exec_fsm

Overview:
Parametrised execution FSM for the register-move instruction class: MOVI (immediate to register) and MOV (register to register). It replaces the fixed six-register, zero-extend-only MOVI controller. The block sits beside the other per-opcode FSMs under the top-level controller and drives the shared data bus and the register load enables. It uses an explicit start/busy/done handshake with a latched instruction rather than gating state advance on the live opcode.

Parameters:
DATA_W, 16, bus and register width
NUM_REGS, 6, number of bus-loadable registers; reg_in/reg_out width
FIELD_W, 6, width of the destination and source/immediate fields
OPC_W, 4, opcode width; INSTR_W = OPC_W + 2*FIELD_W
OPC_MOVI, 4'b0111, MOVI opcode
OPC_MOV, 4'b0110, MOV opcode
SIGN_EXT, 0, 1 = sign-extend the immediate to DATA_W; 0 = zero-extend

Ports:
clk  in  1  clock, all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
instr  in  INSTR_W  instruction; [top OPC_W]=opcode, next FIELD_W=dst, low FIELD_W=src/imm
busy  out  1  high in every state except IDLE
pc_inc  out  1  program-counter increment strobe
imm_out  out  1  immediate drive enable onto the bus
imm_val  out  DATA_W  extended immediate
reg_out  out  NUM_REGS  one-hot source register bus drive (MOV)
reg_in  out  NUM_REGS  one-hot destination register load enable
done  out  1  one-cycle completion pulse
err  out  1  one-cycle illegal-instruction flag, coincident with done

Behaviour:
- Reset: while rst_n is low, the FSM is in IDLE, the instruction register is cleared, and all outputs are 0, including imm_val.
- In IDLE, start=1 latches instr into instr_q at that edge and decodes legality. Subsequent changes to instr are ignored until the next IDLE.
- Legal means the opcode is OPC_MOVI or OPC_MOV, dst < NUM_REGS, and for MOV, src < NUM_REGS.
- States and transitions:
  - IDLE -> FETCH on start.
  - FETCH -> DRIVE if the instruction is legal; FETCH -> DONE with err latched if it is illegal.
  - DRIVE -> LATCH.
  - LATCH -> DONE.
  - DONE -> IDLE.
- Outputs are decoded from the registered state and instr_q, so they are glitch-free.
  - FETCH: pc_inc=1. The PC advances even for an illegal instruction.
  - DRIVE: for MOVI, imm_out=1; for MOV, reg_out[src]=1. reg_in=0.
  - LATCH: the DRIVE outputs are held, and reg_in[dst]=1 for exactly this one cycle.
  - DONE: done=1; err=1 only if the instruction was illegal. No drive or load outputs are asserted.
- imm_val = extend(instr_q[FIELD_W-1:0]) using SIGN_EXT. It is valid in DRIVE and LATCH and is 0 in every other state.
- Latency: start edge to done high is 4 cycles (FETCH, DRIVE, LATCH, DONE) for a legal instruction, and 2 cycles for an illegal one. busy is high from the cycle after start until the DONE cycle inclusive.
- start while busy, including during the DONE cycle: ignored, not queued.
- MOV with src == dst is legal: reg_out and reg_in are asserted in LATCH on the same register.
- At most one bit of reg_in and at most one bit of reg_out may be high at any time. imm_out and reg_out are mutually exclusive.
- Reset asserted mid-operation clears all outputs immediately (asynchronously). No partial load survives, because reg_in is forced to 0.

Decomposition:
- Package mov_pkg holds:
  - the state enum (IDLE, FETCH, DRIVE, LATCH, DONE);
  - opcode constants;
  - register index constants (G0=0, P0=1, G1=2, G2=3, G3=4, P1=5), so the index-to-name mapping is defined once;
  - an extend function.
- Natural sub-module: mov_decode, a combinational legality check plus one-hot dst/src generation, so it can be reused by future ALU FSMs.

Test Plan:
1. Reset, then MOVI: instr=0x7045, start pulse -> pc_inc at cycle 1; imm_out=1 and imm_val=0x0005 at cycles 2-3; reg_in=6'b000010 at cycle 3 only; done at cycle 4; busy falls at cycle 5.
2. Sign extension: SIGN_EXT=1, instr=0x70FF -> imm_val=0xFFFF, reg_in=6'b001000 in LATCH. With SIGN_EXT=0 -> imm_val=0x003F.
3. MOV: instr=0x6084 -> reg_out=6'b010000 in cycles 2-3, reg_in=6'b000100 in cycle 3, imm_out stays 0.
4. Illegal destination: instr=0x71C1 (dst=7) -> pc_inc at cycle 1, done=1 and err=1 at cycle 2, reg_in never set. Opcode 0x3 gives the same response.
5. Start while busy: a second start at cycle 2 with a different instr -> ignored. Outputs follow the first instruction and done pulses once.
6. Reset in LATCH: rst_n low during cycle 3 -> reg_in, imm_out and busy go to 0 immediately. After release, the FSM is in IDLE and accepts a new start.
